// File: rtl/snake_body_ctrl.sv
`default_nettype none
// ============================================================================
// snake_body_ctrl : snake-body FIFO sequencer (step, grow, wall collision)
// Rev 1.0
// ============================================================================
module snake_body_ctrl #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int COORD_W  = 8,
  parameter int START_X  = 20,
  parameter int START_Y  = 15,
  parameter int INIT_LEN = 3,
  parameter int MAX_LEN  = 64,
  localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   tick_i,
  input  logic [1:0]             dir_i,
  input  logic                   grow_i,
  output logic                   fifo_write_o,
  output logic                   fifo_read_o,
  output logic [2*COORD_W-1:0]   fifo_wdata_o,
  input  logic [2*COORD_W-1:0]   fifo_rdata_i,
  input  logic                   fifo_empty_i,
  output logic [COORD_W-1:0]     head_x_o,
  output logic [COORD_W-1:0]     head_y_o,
  output logic                   head_valid_o,
  output logic [COORD_W-1:0]     tail_x_o,
  output logic [COORD_W-1:0]     tail_y_o,
  output logic                   tail_valid_o,
  output logic [LEN_W-1:0]       length_o,
  output logic                   dead_o,
  output logic                   busy_o
);

  localparam logic [COORD_W-1:0] c_X_LAST  = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] c_Y_LAST  = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W-1:0] c_START_X = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] c_START_Y = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] c_INIT_X0 = COORD_W'(START_X - INIT_LEN + 1);
  localparam logic [LEN_W-1:0]   c_INIT_LAST = LEN_W'(INIT_LEN - 1);
  localparam logic [LEN_W-1:0]   c_MAX_LEN   = LEN_W'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_INIT  = 3'd2,
    S_RUN   = 3'd3,
    S_CALC  = 3'd4,
    S_PUSH  = 3'd5,
    S_TAIL  = 3'd6,
    S_DEAD  = 3'd7
  } state_t;

  state_t               state_q, state_d;
  logic [COORD_W-1:0]   head_x_q, head_x_d, head_y_q, head_y_d;
  logic [COORD_W-1:0]   tail_x_q, tail_x_d, tail_y_q, tail_y_d;
  logic [LEN_W-1:0]     length_q, length_d;
  logic [1:0]           cur_dir_q, cur_dir_d;
  logic                 grow_pend_q, grow_pend_d;
  logic                 dead_q, dead_d;

  logic [1:0]           w_eff_dir;
  logic                 w_hit;
  logic [COORD_W-1:0]   w_nx, w_ny;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      head_x_q    <= c_START_X;
      head_y_q    <= c_START_Y;
      tail_x_q    <= '0;
      tail_y_q    <= '0;
      length_q    <= '0;
      cur_dir_q   <= 2'd0;
      grow_pend_q <= 1'b0;
      dead_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_x_q    <= head_x_d;
      head_y_q    <= head_y_d;
      tail_x_q    <= tail_x_d;
      tail_y_q    <= tail_y_d;
      length_q    <= length_d;
      cur_dir_q   <= cur_dir_d;
      grow_pend_q <= grow_pend_d;
      dead_q      <= dead_d;
    end
  end

  // A request for the exact opposite direction would fold the snake onto itself.
  always_comb begin
    w_eff_dir = (dir_i == (cur_dir_q ^ 2'd2)) ? cur_dir_q : dir_i;
    w_nx      = head_x_q;
    w_ny      = head_y_q;
    w_hit     = 1'b0;
    case (w_eff_dir)
      2'd0: begin w_nx = head_x_q + COORD_W'(1); w_hit = (head_x_q == c_X_LAST); end
      2'd1: begin w_ny = head_y_q - COORD_W'(1); w_hit = (head_y_q == '0);       end
      2'd2: begin w_nx = head_x_q - COORD_W'(1); w_hit = (head_x_q == '0);       end
      default: begin w_ny = head_y_q + COORD_W'(1); w_hit = (head_y_q == c_Y_LAST); end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    head_x_d     = head_x_q;
    head_y_d     = head_y_q;
    tail_x_d     = tail_x_q;
    tail_y_d     = tail_y_q;
    length_d     = length_q;
    cur_dir_d    = cur_dir_q;
    grow_pend_d  = grow_pend_q | grow_i;
    dead_d       = dead_q;
    fifo_write_o = 1'b0;
    fifo_read_o  = 1'b0;
    head_valid_o = 1'b0;
    tail_valid_o = 1'b0;

    case (state_q)
      S_IDLE, S_DEAD: begin
        if (start_i) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!fifo_empty_i) begin
          fifo_read_o = 1'b1;
        end else begin
          dead_d      = 1'b0;
          length_d    = '0;
          grow_pend_d = 1'b0;
          cur_dir_d   = 2'd0;
          head_x_d    = c_INIT_X0;
          head_y_d    = c_START_Y;
          state_d     = S_INIT;
        end
      end
      // length doubles as the init push index; the last pushed cell is the start cell
      S_INIT: begin
        fifo_write_o = 1'b1;
        head_valid_o = 1'b1;
        length_d     = length_q + LEN_W'(1);
        if (length_q == c_INIT_LAST) state_d  = S_RUN;
        else                         head_x_d = head_x_q + COORD_W'(1);
      end
      S_RUN: begin
        if (tick_i) state_d = S_CALC;
      end
      S_CALC: begin
        cur_dir_d = w_eff_dir;
        if (w_hit) begin
          dead_d  = 1'b1;
          state_d = S_DEAD;
        end else begin
          head_x_d = w_nx;
          head_y_d = w_ny;
          state_d  = S_PUSH;
        end
      end
      S_PUSH: begin
        fifo_write_o = 1'b1;
        head_valid_o = 1'b1;
        grow_pend_d  = grow_i;
        if (grow_pend_q && (length_q < c_MAX_LEN)) begin
          length_d = length_q + LEN_W'(1);
          state_d  = S_RUN;
        end else begin
          fifo_read_o = 1'b1;
          state_d     = S_TAIL;
        end
      end
      S_TAIL: begin
        tail_valid_o = 1'b1;
        tail_x_d     = fifo_rdata_i[2*COORD_W-1 -: COORD_W];
        tail_y_d     = fifo_rdata_i[COORD_W-1:0];
        state_d      = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fifo_wdata_o = {head_x_q, head_y_q};
  assign head_x_o     = head_x_q;
  assign head_y_o     = head_y_q;
  // The popped word is only valid in TAIL, so show it directly during the pulse.
  assign tail_x_o     = (state_q == S_TAIL) ? fifo_rdata_i[2*COORD_W-1 -: COORD_W] : tail_x_q;
  assign tail_y_o     = (state_q == S_TAIL) ? fifo_rdata_i[COORD_W-1:0] : tail_y_q;
  assign length_o     = length_q;
  assign dead_o       = dead_q;
  assign busy_o       = !((state_q == S_RUN) || (state_q == S_IDLE) || (state_q == S_DEAD));

endmodule
`default_nettype wire

// File: tb/tb_snake_body_ctrl.sv
`default_nettype none
// ============================================================================
// tb_snake_body_ctrl : directed bench with head/tail scoreboard and FIFO model
// Rev 1.0
// ============================================================================
module tb_snake_body_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start = 0, tick = 0, grow = 0;
  logic [1:0] dir = 0;
  logic       start2 = 0, tick2 = 0, grow2 = 0;

  logic [1:0]  fwr, frdq, fempty;
  logic [15:0] fwd [2];
  logic [15:0] frd [2];
  logic [15:0] fmem [2][64];
  int          fwp [2], frp [2], fcnt [2];

  logic [7:0] head_x, head_y, tail_x, tail_y, head_x2, head_y2, tail_x2, tail_y2;
  logic       head_valid, tail_valid, dead, busy, head_valid2, tail_valid2, dead2, busy2;
  logic [6:0] length;
  logic [2:0] length2;

  snake_body_ctrl u_dut (
    .clk(clk), .rst(rst), .start_i(start), .tick_i(tick), .dir_i(dir), .grow_i(grow),
    .fifo_write_o(fwr[0]), .fifo_read_o(frdq[0]), .fifo_wdata_o(fwd[0]),
    .fifo_rdata_i(frd[0]), .fifo_empty_i(fempty[0]),
    .head_x_o(head_x), .head_y_o(head_y), .head_valid_o(head_valid),
    .tail_x_o(tail_x), .tail_y_o(tail_y), .tail_valid_o(tail_valid),
    .length_o(length), .dead_o(dead), .busy_o(busy)
  );

  snake_body_ctrl #(.MAX_LEN(4)) u_cap (
    .clk(clk), .rst(rst), .start_i(start2), .tick_i(tick2), .dir_i(2'd0), .grow_i(grow2),
    .fifo_write_o(fwr[1]), .fifo_read_o(frdq[1]), .fifo_wdata_o(fwd[1]),
    .fifo_rdata_i(frd[1]), .fifo_empty_i(fempty[1]),
    .head_x_o(head_x2), .head_y_o(head_y2), .head_valid_o(head_valid2),
    .tail_x_o(tail_x2), .tail_y_o(tail_y2), .tail_valid_o(tail_valid2),
    .length_o(length2), .dead_o(dead2), .busy_o(busy2)
  );

  // Body FIFO models: registered read data, combinational empty flag.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (!rst && fwr[k]) fmem[k][fwp[k]] <= fwd[k];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        fwp[k] <= 0; frp[k] <= 0; fcnt[k] <= 0; frd[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (fwr[k]) fwp[k] <= (fwp[k] + 1) % 64;
        if (frdq[k] && fcnt[k] > 0) begin
          frd[k] <= fmem[k][frp[k]];
          frp[k] <= (frp[k] + 1) % 64;
        end
        fcnt[k] <= fcnt[k] + (fwr[k] ? 1 : 0) - ((frdq[k] && fcnt[k] > 0) ? 1 : 0);
      end
    end
  end

  assign fempty[0] = (fcnt[0] == 0);
  assign fempty[1] = (fcnt[1] == 0);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // Reference model of the main instance
  logic [15:0] exp_head [$];
  logic [15:0] exp_tail [$];
  logic [15:0] body [$];
  int mx = 20, my = 15, mdir = 0, mlen = 0;
  bit mgrow = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (head_valid) begin
        if (exp_head.size() == 0) chk("head_unexpected", 1, 0);
        else begin
          logic [15:0] e;
          e = exp_head.pop_front();
          chk("head_xy", {head_x, head_y}, e);
          chk("fifo_wdata", fwd[0], e);
        end
      end
      if (tail_valid) begin
        if (exp_tail.size() == 0) chk("tail_unexpected", 1, 0);
        else chk("tail_xy", {tail_x, tail_y}, exp_tail.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_tick(input int d, output bit wall);
    int ed, nx, ny;
    ed = (d == (mdir + 2) % 4) ? mdir : d;
    mdir = ed;
    nx = mx + ((ed == 0) ? 1 : 0) - ((ed == 2) ? 1 : 0);
    ny = my + ((ed == 3) ? 1 : 0) - ((ed == 1) ? 1 : 0);
    wall = (nx < 0) || (nx >= 40) || (ny < 0) || (ny >= 30);
    if (!wall) begin
      mx = nx; my = ny;
      exp_head.push_back({8'(mx), 8'(my)});
      body.push_back({8'(mx), 8'(my)});
      if (mgrow && mlen < 64) mlen++;
      else exp_tail.push_back(body.pop_front());
      mgrow = 0;
    end
  endtask

  task automatic do_step(input int d, output bit wall);
    bit grew;
    grew = mgrow && (mlen < 64);
    model_tick(d, wall);
    dir = 2'(d); tick = 1; cyc(1); tick = 0;
    cyc(1);
    if (wall) begin
      chk("dead_rise_t2", dead, 1);
      chk("no_write_on_wall", fwr[0], 0);
    end else begin
      chk("head_valid_t2", head_valid, 1);
      chk("fifo_read_t2", frdq[0], !grew);
    end
    cyc(1);
    if (!wall) chk("tail_valid_t3", tail_valid, !grew);
    cyc(1);
    chk("length", length, mlen);
  endtask

  task automatic pulse_grow();
    grow = 1; cyc(1); grow = 0;
    mgrow = 1;
  endtask

  task automatic restart();
    int n = 0;
    int occ;
    bit done = 0;
    occ = body.size();
    start = 1; cyc(1); start = 0;
    body.delete();
    for (int i = 0; i < 3; i++) begin
      exp_head.push_back({8'(18 + i), 8'd15});
      body.push_back({8'(18 + i), 8'd15});
    end
    mx = 20; my = 15; mdir = 0; mlen = 3; mgrow = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin done = 1; break; end
      if (frdq[0]) n++;
      cyc(1);
    end
    chk("restart_done", done, 1);
    chk("drain_reads", n, occ);
    chk("restart_len", length, 3);
    chk("restart_dead", dead, 0);
    chk("restart_head", {head_x, head_y}, {8'd20, 8'd15});
    chk("fifo_occupancy", fcnt[0], 3);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1, "bench timed out");
  end

  initial begin
    bit w;
    cyc(2);
    chk("rst_head", {head_x, head_y}, {8'd20, 8'd15});
    chk("rst_len", length, 0);
    chk("rst_dead", dead, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {fwr[0], frdq[0], head_valid, tail_valid}, 0);
    chk("rst_tail", {tail_x, tail_y}, 0);
    rst = 0;
    cyc(1);

    restart();
    do_step(0, w);
    do_step(2, w);
    chk("reverse_dropped", head_x, 22);
    pulse_grow();
    do_step(0, w);
    do_step(0, w);
    do_step(3, w);
    do_step(1, w);
    chk("down_kept", head_y, 17);

    for (int i = 0; i < 40; i++) begin
      do_step(0, w);
      if (w) break;
    end
    chk("wall_seen", w, 1);
    chk("wall_head", {head_x, head_y}, {8'd39, 8'd17});
    tick = 1; cyc(1); tick = 0; cyc(4);
    chk("dead_ignores_tick", {dead, busy, head_x}, {1'b1, 1'b0, 8'd39});

    restart();
    do_step(0, w);
    for (int i = 0; i < 20; i++) begin
      do_step(1, w);
      if (w) break;
    end
    chk("top_wall_seen", w, 1);
    chk("top_wall_head", {head_x, head_y}, {8'd21, 8'd0});

    start2 = 1; cyc(1); start2 = 0; cyc(6);
    chk("cap_init_len", length2, 3);
    for (int s = 0; s < 4; s++) begin
      if (s < 3) begin grow2 = 1; cyc(1); grow2 = 0; end
      tick2 = 1; cyc(1); tick2 = 0; cyc(1);
      chk("cap_head_valid", head_valid2, 1);
      chk("cap_fifo_read", frdq[1], s != 0);
      cyc(1);
      chk("cap_tail_valid", tail_valid2, s != 0);
      if (s != 0) chk("cap_tail_x", tail_x2, 17 + s);
      cyc(1);
      chk("cap_len", length2, 4);
    end

    restart();
    exp_head.delete(); exp_tail.delete();
    tick = 1; cyc(1); tick = 0;
    rst = 1; cyc(1);
    chk("midstep_rst", {busy, dead, head_valid, length, head_x, head_y},
        {1'b0, 1'b0, 1'b0, 7'd0, 8'd20, 8'd15});
    rst = 0; cyc(2);
    chk("midstep_idle", busy, 0);

    chk("heads_outstanding", exp_head.size(), 0);
    chk("tails_outstanding", exp_tail.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
